// File: rtl/pic_claim_if.sv
// ============================================================================
// Module : pic_claim_if
// Brief  : PIC status/clear and core request/ack bundle for pic_claim.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pic_claim_if #(
  parameter int PIC_INT_NUM = 16,
  parameter int VEC_W       = 4
);
  logic [PIC_INT_NUM-1:0] int_sta;
  logic [PIC_INT_NUM-1:0] int_msk;
  logic                   irq_req;
  logic [VEC_W-1:0]       irq_vec;
  logic                   irq_ack;
  logic                   int_clr_en;
  logic [PIC_INT_NUM-1:0] clr_ints;
  logic                   spur_ack;
  logic [15:0]            ack_cnt;

  modport master (
    output int_sta, int_msk, irq_ack,
    input  irq_req, irq_vec, int_clr_en, clr_ints, spur_ack, ack_cnt
  );

  modport slave (
    input  int_sta, int_msk, irq_ack,
    output irq_req, irq_vec, int_clr_en, clr_ints, spur_ack, ack_cnt
  );
endinterface

`default_nettype wire

// File: rtl/pic_claim.sv
// ============================================================================
// Module : pic_claim
// Brief  : Claims the highest-priority unmasked PIC source, raises a request
//          to the core and issues a one-cycle clear back on acknowledge.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pic_claim #(
  parameter int PIC_INT_NUM = 16,
  parameter int VEC_W       = 4
) (
  input  wire logic     pclk,
  input  wire logic     presetn,
  pic_claim_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PEND   = 2'd1,
    S_CLEAR  = 2'd2,
    S_SETTLE = 2'd3
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic                   r_req, w_req_nxt;
  logic [VEC_W-1:0]       r_vec, w_vec_nxt;
  logic                   r_clr_en, w_clr_en_nxt;
  logic [PIC_INT_NUM-1:0] r_clr_ints, w_clr_ints_nxt;
  logic                   r_spur, w_spur_nxt;
  logic [15:0]            r_ack_cnt, w_cnt_nxt;

  logic [PIC_INT_NUM-1:0] w_pend;
  logic [PIC_INT_NUM-1:0] w_onehot;
  logic [VEC_W-1:0]       w_first;
  logic                   w_any;

  assign w_pend   = bus.int_sta & ~bus.int_msk;
  assign w_any    = |w_pend;
  assign w_onehot = {{(PIC_INT_NUM-1){1'b0}}, 1'b1} << r_vec;

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    w_first = '0;
    for (int i = PIC_INT_NUM - 1; i >= 0; i--) begin
      if (w_pend[i]) w_first = VEC_W'(i);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_req_nxt      = r_req;
    w_vec_nxt      = r_vec;
    w_clr_en_nxt   = 1'b0;
    w_clr_ints_nxt = '0;
    w_spur_nxt     = 1'b0;
    w_cnt_nxt      = r_ack_cnt;
    unique case (r_state)
      S_IDLE: begin
        w_spur_nxt = bus.irq_ack;
        if (w_any) begin
          w_vec_nxt   = w_first;
          w_req_nxt   = 1'b1;
          w_state_nxt = S_PEND;
        end
      end
      S_PEND: begin
        // Ack takes precedence over a source withdrawn in the same cycle.
        if (bus.irq_ack) begin
          w_req_nxt      = 1'b0;
          w_clr_en_nxt   = 1'b1;
          w_clr_ints_nxt = w_onehot;
          w_cnt_nxt      = r_ack_cnt + 16'd1;
          w_state_nxt    = S_CLEAR;
        end else if (!w_pend[r_vec]) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      S_CLEAR: begin
        w_spur_nxt  = bus.irq_ack;
        w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        w_spur_nxt  = bus.irq_ack;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_vec      <= '0;
      r_clr_en   <= 1'b0;
      r_clr_ints <= '0;
      r_spur     <= 1'b0;
      r_ack_cnt  <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_req      <= w_req_nxt;
      r_vec      <= w_vec_nxt;
      r_clr_en   <= w_clr_en_nxt;
      r_clr_ints <= w_clr_ints_nxt;
      r_spur     <= w_spur_nxt;
      r_ack_cnt  <= w_cnt_nxt;
    end
  end

  assign bus.irq_req    = r_req;
  assign bus.irq_vec    = r_vec;
  assign bus.int_clr_en = r_clr_en;
  assign bus.clr_ints   = r_clr_ints;
  assign bus.spur_ack   = r_spur;
  assign bus.ack_cnt    = r_ack_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pic_claim.sv
// ============================================================================
// Module : tb_pic_claim
// Brief  : Table-driven self-checking bench for pic_claim.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pic_claim;

  logic pclk;
  logic presetn;

  pic_claim_if #(.PIC_INT_NUM(16), .VEC_W(4)) bus ();

  pic_claim #(.PIC_INT_NUM(16), .VEC_W(4)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic [15:0] sta;
    logic [15:0] msk;
    logic        ack;
    logic        req;
    logic [3:0]  vec;
    logic        clr_en;
    logic [15:0] clr;
    logic        spur;
    logic [15:0] cnt;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t exp_q[$];
  vec_t tbl[47];

  function automatic vec_t mk(logic [15:0] sta, logic [15:0] msk, logic ack,
                              logic req, logic [3:0] vec, logic clr_en,
                              logic [15:0] clr, logic spur, logic [15:0] cnt);
    vec_t v;
    v.sta = sta; v.msk = msk; v.ack = ack; v.req = req; v.vec = vec;
    v.clr_en = clr_en; v.clr = clr; v.spur = spur; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input vec_t e);
    n_vec++;
    if (bus.irq_req !== e.req || bus.irq_vec !== e.vec ||
        bus.int_clr_en !== e.clr_en || bus.clr_ints !== e.clr ||
        bus.spur_ack !== e.spur || bus.ack_cnt !== e.cnt) begin
      n_err++;
      $display("FAIL %s: got req=%b vec=%0d clr_en=%b clr=%h spur=%b cnt=%h, want req=%b vec=%0d clr_en=%b clr=%h spur=%b cnt=%h",
               name, bus.irq_req, bus.irq_vec, bus.int_clr_en, bus.clr_ints,
               bus.spur_ack, bus.ack_cnt, e.req, e.vec, e.clr_en, e.clr,
               e.spur, e.cnt);
    end
  endtask

  task automatic apply(input string name, input vec_t v);
    vec_t e;
    bus.int_sta = v.sta;
    bus.int_msk = v.msk;
    bus.irq_ack = v.ack;
    exp_q.push_back(v);
    @(posedge pclk);
    #1;
    e = exp_q.pop_front();
    chk(name, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // sta, msk, ack | req, vec, clr_en, clr, spur, cnt
    tbl[0]  = mk(16'h0020, 16'h0000, 1'b0, 1'b1, 4'd5,  1'b0, 16'h0000, 1'b0, 16'd0);
    tbl[1]  = mk(16'h0020, 16'h0000, 1'b1, 1'b0, 4'd5,  1'b1, 16'h0020, 1'b0, 16'd1);
    tbl[2]  = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 4'd5,  1'b0, 16'h0000, 1'b0, 16'd1);
    tbl[3]  = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 4'd5,  1'b0, 16'h0000, 1'b0, 16'd1);
    tbl[4]  = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 4'd5,  1'b0, 16'h0000, 1'b0, 16'd1);
    tbl[5]  = mk(16'h8100, 16'h0000, 1'b0, 1'b1, 4'd8,  1'b0, 16'h0000, 1'b0, 16'd1);
    tbl[6]  = mk(16'h8104, 16'h0000, 1'b0, 1'b1, 4'd8,  1'b0, 16'h0000, 1'b0, 16'd1);
    tbl[7]  = mk(16'h8104, 16'h0000, 1'b1, 1'b0, 4'd8,  1'b1, 16'h0100, 1'b0, 16'd2);
    tbl[8]  = mk(16'h8004, 16'h0000, 1'b0, 1'b0, 4'd8,  1'b0, 16'h0000, 1'b0, 16'd2);
    tbl[9]  = mk(16'h8004, 16'h0000, 1'b0, 1'b0, 4'd8,  1'b0, 16'h0000, 1'b0, 16'd2);
    tbl[10] = mk(16'h8004, 16'h0000, 1'b0, 1'b1, 4'd2,  1'b0, 16'h0000, 1'b0, 16'd2);
    tbl[11] = mk(16'h8004, 16'h0000, 1'b1, 1'b0, 4'd2,  1'b1, 16'h0004, 1'b0, 16'd3);
    tbl[12] = mk(16'h8000, 16'h0000, 1'b0, 1'b0, 4'd2,  1'b0, 16'h0000, 1'b0, 16'd3);
    tbl[13] = mk(16'h8000, 16'h0000, 1'b0, 1'b0, 4'd2,  1'b0, 16'h0000, 1'b0, 16'd3);
    tbl[14] = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 4'd2,  1'b0, 16'h0000, 1'b0, 16'd3);
    tbl[15] = mk(16'h0003, 16'h0001, 1'b0, 1'b1, 4'd1,  1'b0, 16'h0000, 1'b0, 16'd3);
    tbl[16] = mk(16'h0003, 16'h0003, 1'b0, 1'b0, 4'd1,  1'b0, 16'h0000, 1'b0, 16'd3);
    tbl[17] = mk(16'h0003, 16'h0003, 1'b0, 1'b0, 4'd1,  1'b0, 16'h0000, 1'b0, 16'd3);
    tbl[18] = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 4'd1,  1'b0, 16'h0000, 1'b0, 16'd3);
    tbl[19] = mk(16'h0000, 16'h0000, 1'b1, 1'b0, 4'd1,  1'b0, 16'h0000, 1'b1, 16'd3);
    tbl[20] = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 4'd1,  1'b0, 16'h0000, 1'b0, 16'd3);
    tbl[21] = mk(16'h0010, 16'h0000, 1'b0, 1'b1, 4'd4,  1'b0, 16'h0000, 1'b0, 16'd3);
    tbl[22] = mk(16'h0010, 16'h0000, 1'b1, 1'b0, 4'd4,  1'b1, 16'h0010, 1'b0, 16'd4);
    tbl[23] = mk(16'h0000, 16'h0000, 1'b1, 1'b0, 4'd4,  1'b0, 16'h0000, 1'b1, 16'd4);
    tbl[24] = mk(16'h0000, 16'h0000, 1'b1, 1'b0, 4'd4,  1'b0, 16'h0000, 1'b1, 16'd4);
    tbl[25] = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 4'd4,  1'b0, 16'h0000, 1'b0, 16'd4);
    tbl[26] = mk(16'h0040, 16'h0000, 1'b0, 1'b1, 4'd6,  1'b0, 16'h0000, 1'b0, 16'd4);
    tbl[27] = mk(16'h0000, 16'h0000, 1'b1, 1'b0, 4'd6,  1'b1, 16'h0040, 1'b0, 16'd5);
    tbl[28] = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 4'd6,  1'b0, 16'h0000, 1'b0, 16'd5);
    tbl[29] = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 4'd6,  1'b0, 16'h0000, 1'b0, 16'd5);
    tbl[30] = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 4'd6,  1'b0, 16'h0000, 1'b0, 16'd5);
    tbl[31] = mk(16'h8000, 16'h0000, 1'b0, 1'b1, 4'd15, 1'b0, 16'h0000, 1'b0, 16'd5);
    tbl[32] = mk(16'h8000, 16'h8000, 1'b0, 1'b0, 4'd15, 1'b0, 16'h0000, 1'b0, 16'd5);
    tbl[33] = mk(16'h8000, 16'h0000, 1'b0, 1'b1, 4'd15, 1'b0, 16'h0000, 1'b0, 16'd5);
    tbl[34] = mk(16'h8000, 16'h0000, 1'b1, 1'b0, 4'd15, 1'b1, 16'h8000, 1'b0, 16'd6);
    tbl[35] = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 4'd15, 1'b0, 16'h0000, 1'b0, 16'd6);
    tbl[36] = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 4'd15, 1'b0, 16'h0000, 1'b0, 16'd6);
    tbl[37] = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 4'd15, 1'b0, 16'h0000, 1'b0, 16'd6);
    tbl[38] = mk(16'hFFFF, 16'h0000, 1'b0, 1'b1, 4'd0,  1'b0, 16'h0000, 1'b0, 16'd6);
    tbl[39] = mk(16'hFFFF, 16'h0000, 1'b1, 1'b0, 4'd0,  1'b1, 16'h0001, 1'b0, 16'd7);
    tbl[40] = mk(16'hFFFE, 16'h0000, 1'b0, 1'b0, 4'd0,  1'b0, 16'h0000, 1'b0, 16'd7);
    tbl[41] = mk(16'hFFFE, 16'h0000, 1'b0, 1'b0, 4'd0,  1'b0, 16'h0000, 1'b0, 16'd7);
    tbl[42] = mk(16'hFFFE, 16'h0000, 1'b0, 1'b1, 4'd1,  1'b0, 16'h0000, 1'b0, 16'd7);
    tbl[43] = mk(16'hFFFE, 16'h0000, 1'b1, 1'b0, 4'd1,  1'b1, 16'h0002, 1'b0, 16'd8);
    tbl[44] = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 4'd1,  1'b0, 16'h0000, 1'b0, 16'd8);
    tbl[45] = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 4'd1,  1'b0, 16'h0000, 1'b0, 16'd8);
    tbl[46] = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 4'd1,  1'b0, 16'h0000, 1'b0, 16'd8);

    presetn     = 1'b0;
    bus.int_sta = '0;
    bus.int_msk = '0;
    bus.irq_ack = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    presetn = 1'b1;
    chk("reset_state", mk(16'h0, 16'h0, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0, 1'b0, 16'd0));

    for (int i = 0; i < 47; i++) begin
      apply($sformatf("row%0d", i), tbl[i]);
    end

    // Asynchronous reset while the clear strobe is high.
    apply("rst_claim", mk(16'h0001, 16'h0, 1'b0, 1'b1, 4'd0, 1'b0, 16'h0000, 1'b0, 16'd8));
    apply("rst_ack",   mk(16'h0001, 16'h0, 1'b1, 1'b0, 4'd0, 1'b1, 16'h0001, 1'b0, 16'd9));
    #2;
    presetn = 1'b0;
    #1;
    chk("rst_async", mk(16'h0, 16'h0, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 16'd0));
    bus.irq_ack = 1'b0;
    bus.int_sta = '0;
    @(posedge pclk);
    #1;
    presetn = 1'b1;
    apply("rst_idle",   mk(16'h0000, 16'h0, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 16'd0));
    apply("rst_reclaim", mk(16'h0001, 16'h0, 1'b0, 1'b1, 4'd0, 1'b0, 16'h0000, 1'b0, 16'd0));
    apply("rst_ack2",   mk(16'h0001, 16'h0, 1'b1, 1'b0, 4'd0, 1'b1, 16'h0001, 1'b0, 16'd1));
    apply("rst_settle", mk(16'h0000, 16'h0, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 16'd1));
    apply("rst_back",   mk(16'h0000, 16'h0, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 16'd1));

    // Counter wrap from 0xFFFF.
    force dut.r_ack_cnt = 16'hFFFF;
    #1;
    release dut.r_ack_cnt;
    apply("wrap_claim",  mk(16'h0002, 16'h0, 1'b0, 1'b1, 4'd1, 1'b0, 16'h0000, 1'b0, 16'hFFFF));
    apply("wrap_ack",    mk(16'h0002, 16'h0, 1'b1, 1'b0, 4'd1, 1'b1, 16'h0002, 1'b0, 16'h0000));
    apply("wrap_settle", mk(16'h0000, 16'h0, 1'b0, 1'b0, 4'd1, 1'b0, 16'h0000, 1'b0, 16'h0000));
    apply("wrap_idle",   mk(16'h0000, 16'h0, 1'b0, 1'b0, 4'd1, 1'b0, 16'h0000, 1'b0, 16'h0000));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
